// File: rtl/scan_mux_seq.sv
// rtl/scan_mux_seq.sv - registered N:1 channel multiplexer with auto scan and manual select
// Optional per-channel enable mask: define SCAN_MUX_CH_MASK_EN to add the ch_mask_i port.
module scan_mux_seq #(
  parameter int N     = 8,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] sel_in_i,
  input  logic [N*W-1:0]   din_i,
`ifdef SCAN_MUX_CH_MASK_EN
  input  logic [N-1:0]     ch_mask_i,
`endif
  output logic [W-1:0]     dout_o,
  output logic [SEL_W-1:0] ch_o,
  output logic             valid_o,
  output logic             wrap_o
);

  localparam int NP = 1 << SEL_W;
  localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCNT_W-1:0] DLAST = DCNT_W'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              wrap_q, wrap_d;

  // Padded to the full select range so indices >= N read as disabled/zero.
  logic [NP-1:0]     chan_en;
  logic [W-1:0]      lane [NP];
  logic [SEL_W-1:0]  nxt_en;
  logic [SEL_W-1:0]  hi_en;

  always_comb begin
    chan_en = '0;
`ifdef SCAN_MUX_CH_MASK_EN
    chan_en[N-1:0] = ch_mask_i;
`else
    chan_en[N-1:0] = '1;
`endif
    for (int k = 0; k < NP; k++) lane[k] = '0;
    for (int k = 0; k < N; k++) lane[k] = din_i[k*W +: W];
  end

  // Nearest enabled channel after cur (wrapping); farthest offset first so nearest wins.
  always_comb begin
    int j;
    j      = 0;
    nxt_en = cur_q;
    hi_en  = '0;
    for (int k = 0; k < N; k++) begin
      if (chan_en[k]) hi_en = SEL_W'(k);
    end
    for (int i = N; i >= 1; i--) begin
      j = int'(cur_q) + i;
      if (j >= N) j = j - N;
      if (chan_en[j]) nxt_en = SEL_W'(j);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dcnt_d  = dcnt_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = SCAN;
          dcnt_d  = '0;
        end
      end
      SCAN: begin
        if (!en_i) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q != DLAST) begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end else begin
          dcnt_d = '0;
          if (!mode_i) begin
            if (chan_en[cur_q]) begin
              dout_d  = lane[cur_q];
              ch_d    = cur_q;
              valid_d = 1'b1;
              wrap_d  = (cur_q == hi_en);
            end
            cur_d = nxt_en;
          end else if (chan_en[sel_in_i]) begin
            dout_d  = lane[sel_in_i];
            ch_d    = sel_in_i;
            valid_d = 1'b1;
            cur_d   = sel_in_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cur_q   <= '0;
      dcnt_q  <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dcnt_q  <= dcnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign dout_o  = dout_q;
  assign ch_o    = ch_q;
  assign valid_o = valid_q;
  assign wrap_o  = wrap_q;

endmodule

// File: tb/tb_scan_mux_seq.sv
// tb/tb_scan_mux_seq.sv - self-checking bench for scan_mux_seq across four parameter sets
module tb_scan_mux_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  sel3 = '0;
  logic [7:0]  din8 = '0;
  logic [15:0] din16 = '0;

  logic [0:0] dout_a, dout_b, dout_c;
  logic [3:0] dout_d;
  logic [2:0] ch_a, ch_b, ch_c;
  logic [1:0] ch_d;
  logic       valid_a, valid_b, valid_c, valid_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  scan_mux_seq #(.N(8), .W(1), .DWELL(1)) u_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel3), .din_i(din8),
    .dout_o(dout_a), .ch_o(ch_a), .valid_o(valid_a), .wrap_o(wrap_a));

  scan_mux_seq #(.N(8), .W(1), .DWELL(3)) u_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel3), .din_i(din8),
    .dout_o(dout_b), .ch_o(ch_b), .valid_o(valid_b), .wrap_o(wrap_b));

  scan_mux_seq #(.N(6), .W(1), .DWELL(1)) u_c (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel3), .din_i(din8[5:0]),
    .dout_o(dout_c), .ch_o(ch_c), .valid_o(valid_c), .wrap_o(wrap_c));

  scan_mux_seq #(.N(4), .W(4), .DWELL(2)) u_d (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .sel_in_i(sel3[1:0]), .din_i(din16),
    .dout_o(dout_d), .ch_o(ch_d), .valid_o(valid_d), .wrap_o(wrap_d));

  // Reference model: one sample every DWELL enabled cycles of a run, channel chosen by mode.
  int          P_N [4] = '{8, 8, 6, 4};
  int          P_W [4] = '{1, 1, 1, 4};
  int          P_D [4] = '{1, 3, 1, 2};
  bit          m_run [4];
  int          m_cnt [4];
  int          m_cur [4];
  int          m_ch [4];
  logic [15:0] m_dout [4];
  bit          m_valid [4];
  bit          m_wrap [4];

  task automatic model_step(input int i);
    int n, w, dw, sel, pick;
    logic [31:0] d;
    n    = P_N[i];
    w    = P_W[i];
    dw   = P_D[i];
    sel  = (i == 3) ? int'(sel3[1:0]) : int'(sel3);
    d    = (i == 3) ? 32'(din16) : (i == 2) ? 32'(din8[5:0]) : 32'(din8);
    if (rst) begin
      m_run[i] = 0; m_cnt[i] = 0; m_cur[i] = 0;
      m_ch[i] = 0; m_dout[i] = '0; m_valid[i] = 0; m_wrap[i] = 0;
    end else begin
      m_valid[i] = 0;
      m_wrap[i]  = 0;
      if (!m_run[i]) begin
        if (en) begin
          m_run[i] = 1;
          m_cnt[i] = 0;
        end
      end else if (!en) begin
        m_run[i] = 0;
        m_cnt[i] = 0;
      end else begin
        m_cnt[i]++;
        if (m_cnt[i] == dw) begin
          m_cnt[i] = 0;
          pick = mode ? sel : m_cur[i];
          if (pick < n) begin
            m_dout[i]  = 16'((d >> (pick * w)) & ((1 << w) - 1));
            m_ch[i]    = pick;
            m_valid[i] = 1;
            m_wrap[i]  = !mode && (pick == n - 1);
            m_cur[i]   = mode ? pick : (pick + 1) % n;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a.dout", 16'(dout_a), m_dout[0]);
    chk("a.ch", 16'(ch_a), 16'(m_ch[0]));
    chk("a.valid", 16'(valid_a), 16'(m_valid[0]));
    chk("a.wrap", 16'(wrap_a), 16'(m_wrap[0]));
    chk("b.dout", 16'(dout_b), m_dout[1]);
    chk("b.ch", 16'(ch_b), 16'(m_ch[1]));
    chk("b.valid", 16'(valid_b), 16'(m_valid[1]));
    chk("b.wrap", 16'(wrap_b), 16'(m_wrap[1]));
    chk("c.dout", 16'(dout_c), m_dout[2]);
    chk("c.ch", 16'(ch_c), 16'(m_ch[2]));
    chk("c.valid", 16'(valid_c), 16'(m_valid[2]));
    chk("c.wrap", 16'(wrap_c), 16'(m_wrap[2]));
    chk("d.dout", 16'(dout_d), m_dout[3]);
    chk("d.ch", 16'(ch_d), 16'(m_ch[3]));
    chk("d.valid", 16'(valid_d), 16'(m_valid[3]));
    chk("d.wrap", 16'(wrap_d), 16'(m_wrap[3]));
  endtask

  task automatic step(input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      for (int i = 0; i < 4; i++) model_step(i);
      #1;
      cyc++;
      check_all();
    end
  endtask

  initial begin
    // Reset, then the fixed-pattern auto scan.
    rst = 1'b1; en = 1'b0;
    step(2);
    rst = 1'b0; din8 = 8'b11001100; din16 = 16'hA5C3;
    step(2);
    en = 1'b1;
    step(30);
    // Manual picks, including an out-of-range index for the 6-channel instance.
    mode = 1'b1; sel3 = 3'd5;
    step(3);
    sel3 = 3'd6;
    step(3);
    sel3 = 3'd7;
    step(6);
    mode = 1'b0;
    step(12);
    // Reset pulse mid-scan, then restart.
    rst = 1'b1;
    step(1);
    rst = 1'b0; en = 1'b0;
    step(2);
    en = 1'b1;
    step(10);
    // Enable pause mid-scan.
    en = 1'b0;
    step(5);
    en = 1'b1;
    step(12);
    // Randomized traffic.
    for (int r = 0; r < 1500; r++) begin
      rst   = ($urandom_range(63) == 0);
      en    = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) mode = ~mode;
      sel3  = 3'($urandom);
      din8  = 8'($urandom);
      din16 = 16'($urandom);
      step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
